spi_sdc_responder: RTL

SPI_SDC_RESPONDER -- requirements
Module: spi_sdc_responder

---
 rtl/sdc_pkg.sv | 30 +++
 rtl/sdc_crc7.sv | 33 +++
 rtl/spi_sdc_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_pkg.sv
// Shared constants for the SPI-mode SD card command responder: command indices,
// R1 bit positions, FSM state codes and the CRC7 polynomial with its serial step.
package sdc_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC_ERR = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RECV   = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // x^7 + x^3 + 1, leading term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
        logic fb;
        fb = data ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdc_crc7.sv
// Serial CRC7 accumulator, one bit per enabled cycle. A clear in the same cycle as
// an enable restarts from zero and folds in that first bit.
module sdc_crc7
    import sdc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       data_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] base;

    always_comb begin
        base  = clear_i ? 7'h00 : crc_q;
        crc_d = enable_i ? crc7_step(base, data_i) : base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/spi_sdc_responder.sv
// SPI-mode SD card command receiver and R1 responder (one SPI bit per i_clk).
// Define SDC_RESP_CRC_CHECK_EN to check CRC7 on received frames and report R1 CRC errors.
module spi_sdc_responder
    import sdc_pkg::*;
#(
    parameter int NCR = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_cmd_valid,
    output logic [5:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic        o_idle
);

    localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

    logic [2:0]  state_q, state_d;
    logic        armed_q, armed_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [46:0] frame_q, frame_d;
    logic [7:0]  r1_q, r1_d;
    logic        miso_q, miso_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic        idle_q, idle_d;
    logic        app_q, app_d;

    logic        frame_start;
    logic        frame_ok;
    logic        crc_err;
    logic [5:0]  cmd_field;
    logic [31:0] arg_field;
    logic        idle_x;
    logic        app_x;
    logic        illegal;
    logic [7:0]  r1_x;

    // Bit 47 (start bit, always 0) is not stored; frame_q holds bits 46..0.
    assign frame_start = (state_q == ST_IDLE) && !i_cs && armed_q && !i_mosi;
    assign cmd_field   = frame_q[45:40];
    assign arg_field   = frame_q[39:8];
    assign frame_ok    = frame_q[46] && frame_q[0];

`ifdef SDC_RESP_CRC_CHECK_EN
    logic [6:0] crc_calc;
    logic       crc_en;

    assign crc_en = frame_start || ((state_q == ST_RECV) && !i_cs && (cnt_q >= 6'd8));

    sdc_crc7 u_crc7 (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clear_i  (frame_start),
        .enable_i (crc_en),
        .data_i   (i_mosi),
        .crc_o    (crc_calc)
    );

    assign crc_err = (crc_calc != frame_q[7:1]);
`else
    assign crc_err = 1'b0;
`endif

    // Card state after executing the received command, and the R1 it produces.
    always_comb begin
        idle_x  = idle_q;
        app_x   = app_q;
        illegal = 1'b0;
        case (cmd_field)
            CMD0: begin
                idle_x = 1'b1;
                app_x  = 1'b0;
            end
            CMD8, CMD58: app_x = 1'b0;
            CMD55: app_x = 1'b1;
            CMD41: begin
                app_x = 1'b0;
                if (app_q) begin
                    idle_x = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        r1_x              = 8'h00;
        r1_x[R1_IDLE]     = idle_x;
        r1_x[R1_ILLEGAL]  = illegal;
        if (crc_err) begin
            r1_x             = 8'h00;
            r1_x[R1_CRC_ERR] = 1'b1;
            r1_x[R1_IDLE]    = idle_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        r1_d        = r1_q;
        miso_d      = miso_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        idle_d      = idle_q;
        app_d       = app_q;

        if (i_cs) begin
            state_d = ST_IDLE;
            miso_d  = 1'b1;
            armed_d = 1'b0;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_d = ST_RECV;
                        armed_d = 1'b0;
                        frame_d = '0;
                        cnt_d   = 6'd46;
                    end else if (i_mosi) begin
                        armed_d = 1'b1;
                    end
                end
                ST_RECV: begin
                    frame_d = {frame_q[45:0], i_mosi};
                    if (cnt_q == 6'd0) begin
                        state_d = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                ST_DECODE: begin
                    if (!frame_ok) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 6'd0;
                        r1_d    = r1_x;
                        if (!crc_err) begin
                            cmd_valid_d = 1'b1;
                            cmd_d       = cmd_field;
                            arg_d       = arg_field;
                            idle_d      = idle_x;
                            app_d       = app_x;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == NCR_LAST) begin
                        state_d = ST_RESP;
                        miso_d  = r1_q[7];
                        r1_d    = {r1_q[6:0], 1'b1};
                        cnt_d   = 6'd7;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_RESP: begin
                    // cnt_q counts R1 bits still to drive after bit 7
                    if (cnt_q == 6'd0) begin
                        state_d = ST_IDLE;
                        miso_d  = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        miso_d = r1_q[7];
                        r1_d   = {r1_q[6:0], 1'b1};
                        cnt_d  = cnt_q - 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b1;
                    armed_d = 1'b0;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            cnt_q       <= 6'd0;
            frame_q     <= '0;
            r1_q        <= 8'h00;
            miso_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 6'd0;
            arg_q       <= 32'd0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            r1_q        <= r1_d;
            miso_q      <= miso_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
        end
    end

    assign o_miso      = miso_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_arg       = arg_q;
    assign o_idle      = idle_q;

endmodule
